// File: rtl/vedic_mul_acc_if.sv
// ---------------------------------------------------------------------------
// vedic_mul_acc_if
//   Groups the product-beat input stream and the result output stream of the
//   vedic_mul_acc packet accumulator.
//
//   Parameter
//     GUARD     : guard bits above the 128-bit product. It must match the GUARD
//                 of the vedic_mul_acc instance this bus connects to.
//
//   Signals
//     in_valid  : product beat valid                  (upstream -> block)
//     in_ready  : block can accept a beat             (block -> upstream)
//     in_prod   : 128-bit unsigned product            (upstream -> block)
//     in_last   : beat is the final beat of a packet  (upstream -> block)
//     out_valid : result valid                        (block -> downstream)
//     out_ready : downstream accepts the result       (downstream -> block)
//     out_acc   : packet sum, 128+GUARD bits          (block -> downstream)
//     out_count : number of beats in the packet       (block -> downstream)
//     out_ovf   : accumulator overflowed in packet    (block -> downstream)
//
//   Modports
//     master : environment side (drives the beats and out_ready)
//     slave  : accumulator side (the vedic_mul_acc port)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface vedic_mul_acc_if #(
  parameter int GUARD = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [127:0]         in_prod;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [127+GUARD:0]   out_acc;
  logic [15:0]          out_count;
  logic                 out_ovf;

  modport master (
    output in_valid,
    output in_prod,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_acc,
    input  out_count,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_prod,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_acc,
    output out_count,
    output out_ovf
  );
endinterface

// File: rtl/vedic_mul_acc.sv
// ---------------------------------------------------------------------------
// vedic_mul_acc
//   Packet accumulator for the 128-bit products of a 64x64 vedic multiplier.
//   Beats of a packet are summed into a 128+GUARD bit accumulator together
//   with a saturating 16-bit beat counter and a sticky overflow flag. The beat
//   flagged in_last closes the packet: the result (including that beat) is
//   registered onto the output bus one cycle later and held until the
//   downstream handshake completes. No new beat is accepted while a result is
//   held.
//
//   Parameter
//     GUARD       : accumulator guard bits above the product, legal 1..32
//
//   Ports
//     clk         : clock, all state changes on its rising edge
//     rst_n       : asynchronous active-low reset
//     clear       : synchronous abort, wins over every other event
//     bus         : vedic_mul_acc_if.slave (in_* beat stream, out_* result)
//
//   Configuration macro
//     VEDIC_ACC_SAT_EN : when defined the accumulator saturates at all-ones
//                        on overflow; otherwise it wraps modulo 2^(128+GUARD).
//                        The overflow flag is set in both builds.
//
//   States
//     IDLE  : no beat of the current packet accepted yet
//     ACCUM : at least one beat accepted, last beat not seen
//     DRAIN : result held on the output bus
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vedic_mul_acc #(
  parameter int GUARD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  vedic_mul_acc_if.slave   bus
);

  localparam int W = 128 + GUARD;

  generate
    if (GUARD < 1 || GUARD > 32) begin : g_bad_guard
      $error("vedic_mul_acc: GUARD must be in 1..32");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;

  // running packet state
  logic [W-1:0]    acc;
  logic [15:0]     count;
  logic            ovf;

  // held result
  logic            out_valid_q;
  logic [W-1:0]    out_acc_q;
  logic [15:0]     out_count_q;
  logic            out_ovf_q;

  // combinational next values for an accepted beat
  logic            can_accept;
  logic            accept;
  logic [W:0]      sum_ext;
  logic            carry;
  logic [W-1:0]    acc_add;
  logic [15:0]     count_add;
  logic            ovf_add;

  // in_ready is a function of the registered state and the live clear input,
  // so a clear in the same cycle as a valid beat prevents the handshake.
  assign can_accept = (state != DRAIN) && !clear;
  assign accept     = bus.in_valid && can_accept;

  // One extra bit on the left captures the carry out of the top accumulator bit.
  assign sum_ext = {1'b0, acc} + {{(GUARD + 1){1'b0}}, bus.in_prod};
  assign carry   = sum_ext[W];

`ifdef VEDIC_ACC_SAT_EN
  // Once saturated, any further non-zero add carries again and stays at max.
  assign acc_add = carry ? {W{1'b1}} : sum_ext[W-1:0];
`else
  assign acc_add = sum_ext[W-1:0];
`endif

  assign count_add = (count == 16'hFFFF) ? count : (count + 16'd1);
  assign ovf_add   = ovf | carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else if (clear) begin
      // Abort: drop the partial packet and any held result. The data outputs
      // keep their last values; out_valid low marks them as meaningless.
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (bus.in_last) begin
              out_valid_q <= 1'b1;
              out_acc_q   <= acc_add;
              out_count_q <= count_add;
              out_ovf_q   <= ovf_add;
              acc         <= '0;
              count       <= '0;
              ovf         <= 1'b0;
              state       <= DRAIN;
            end else begin
              acc         <= acc_add;
              count       <= count_add;
              ovf         <= ovf_add;
              state       <= ACCUM;
            end
          end
        end
        DRAIN: begin
          // out_valid is always 1 here, so out_ready alone completes the handshake.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = can_accept;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: doc/vedic_mul_acc.md
VEDIC_MUL_ACC -- requirements
Module: vedic_mul_acc

Interface
REQ-001 SHALL have parameter GUARD, default 8: number of accumulator guard bits above the 128-bit product; legal range 1..32.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port clear, input, 1: synchronous packet abort.
REQ-005 SHALL have port in_valid, input, 1: product beat valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept a beat.
REQ-007 SHALL have port in_prod, input, 128: unsigned product from the 64x64 vedic multiplier.
REQ-008 SHALL have port in_last, input, 1: beat is the final beat of a packet.
REQ-009 SHALL have port out_valid, output, 1: result valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-011 SHALL have port out_acc, output, 128+GUARD: accumulated sum of the packet.
REQ-012 SHALL have port out_count, output, 16: number of beats in the packet.
REQ-013 SHALL have port out_ovf, output, 1: accumulator exceeded its width during the packet.

Function
REQ-014 SHALL implement three states: IDLE (no beats accepted), ACCUM (one or more beats accepted, no last beat), and DRAIN (result held).
REQ-015 SHALL drive in_ready = 1 in IDLE and ACCUM and 0 in DRAIN or while clear = 1.
REQ-016 SHALL treat a beat as accepted only when in_valid and in_ready are both 1; on acceptance, acc <= acc + zero-extended in_prod and count <= count + 1, with count saturating at 0xFFFF.
REQ-017 SHALL set a sticky ovf flag when an accepted add produces a carry out of bit 127+GUARD; by default the accumulator wraps modulo 2^(128+GUARD).
REQ-018 SHALL, on an accepted beat with in_last = 1, load out_acc, out_count and out_ovf with the values that include that beat; clear acc, count and ovf; and move to DRAIN.
REQ-019 SHALL assert out_valid in the cycle after the last beat is accepted (latency 1 cycle).
REQ-020 SHALL hold out_valid, out_acc, out_count and out_ovf stable in DRAIN until out_valid and out_ready are both 1, then move to IDLE with out_valid = 0 in the next cycle.
REQ-021 SHALL move from IDLE to ACCUM on an accepted beat without in_last, and from IDLE directly to DRAIN on an accepted beat with in_last (single-beat packet).
REQ-022 SHALL give clear priority over all other events: acc, count, ovf and out_valid go to 0, the state goes to IDLE, and any same-cycle input beat or output handshake is discarded.
REQ-023 SHALL ignore in_prod and in_last when in_valid = 0, and SHALL ignore out_ready when out_valid = 0.

Reset
REQ-024 SHALL, while rst_n = 0, immediately force state = IDLE, acc = 0, count = 0, ovf = 0, out_valid = 0, out_acc = 0, out_count = 0 and out_ovf = 0, independent of clk.
REQ-025 SHALL, when reset is asserted mid-packet or in DRAIN, discard the partial sum and the held result without emitting them.
REQ-026 SHALL drive in_ready = 1 in the first cycle after rst_n deasserts.

Configuration
REQ-027 SHALL, when macro VEDIC_ACC_SAT_EN is defined, saturate the accumulator at all-ones on overflow instead of wrapping; ovf SHALL still be set.
REQ-028 SHALL, when VEDIC_ACC_SAT_EN is undefined, wrap the accumulator modulo 2^(128+GUARD) as in REQ-017.

Verification
REQ-029 SHALL cover: assert rst_n = 0 mid-packet, then release -> out_valid = 0, in_ready = 1, and the next packet sums from 0.
REQ-030 SHALL cover: a single beat with in_prod = 0x5 and in_last = 1 -> the next cycle out_valid = 1, out_acc = 0x5, out_count = 1, out_ovf = 0.
REQ-031 SHALL cover: beats 0x1, 0x2, 0x3 with in_last on the third -> out_acc = 0x6, out_count = 3.
REQ-032 SHALL cover: out_ready held 0 for 4 cycles in DRAIN -> outputs stable and in_ready = 0; out_ready = 1 -> IDLE and out_valid = 0 the next cycle.
REQ-033 SHALL cover: GUARD = 1, three beats of 2^128-1 -> out_ovf = 1 and out_acc = 2^128-3; with VEDIC_ACC_SAT_EN defined, out_acc = 2^129-1.
REQ-034 SHALL cover: clear pulsed after two beats, in the same cycle as a valid beat -> that beat is dropped; the following packet of 0x7 with in_last gives out_acc = 0x7, out_count = 1.
